// File: rtl/hvac_zone_controller_if.sv
// Interface for the zone controller: shared mode/thresholds, per-zone temperatures
// and the per-zone drive/status outputs.
interface hvac_zone_controller_if #(
  parameter int N_ZONES = 4,
  parameter int TEMP_W  = 5
);
  logic [1:0]                mode;
  logic [TEMP_W-1:0]         thr_heat;
  logic [TEMP_W-1:0]         thr_target;
  logic [TEMP_W-1:0]         thr_cool;
  logic [N_ZONES*TEMP_W-1:0] temperature;
  logic [N_ZONES-1:0]        heating;
  logic [N_ZONES-1:0]        cooling;
  logic [N_ZONES-1:0]        lockout;
  logic                      cfg_err;

  modport master (
    output mode, thr_heat, thr_target, thr_cool, temperature,
    input  heating, cooling, lockout, cfg_err
  );

  modport slave (
    input  mode, thr_heat, thr_target, thr_cool, temperature,
    output heating, cooling, lockout, cfg_err
  );
endinterface

// File: rtl/hvac_zone_controller.sv
// Multi-zone thermostat: per-zone IDLE/HEAT/COOL hysteresis FSM with min-on/min-off
// dwell timers, shared mode and runtime thresholds, all outputs registered.
module hvac_zone_controller #(
  parameter int N_ZONES        = 4,
  parameter int TEMP_W         = 5,
  parameter int MIN_ON_CYCLES  = 4,
  parameter int MIN_OFF_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  hvac_zone_controller_if.slave  bus
);

  localparam int MAX_DWELL = (MIN_ON_CYCLES > MIN_OFF_CYCLES) ? MIN_ON_CYCLES : MIN_OFF_CYCLES;
  localparam int CNT_W     = $clog2(MAX_DWELL + 1);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MIN_OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAT = 2'b01,
    COOL = 2'b10
  } state_e;

  state_e             state_q [N_ZONES];
  state_e             state_d [N_ZONES];
  logic [CNT_W-1:0]   cnt_q   [N_ZONES];
  logic [CNT_W-1:0]   cnt_d   [N_ZONES];
  logic [N_ZONES-1:0] heating_q, heating_d;
  logic [N_ZONES-1:0] cooling_q, cooling_d;
  logic [N_ZONES-1:0] lockout_q, lockout_d;
  logic               cfg_err_q, cfg_err_d;

  logic               cfg_ok;
  logic               heat_allowed;
  logic               cool_allowed;
  logic [TEMP_W-1:0]  zone_temp [N_ZONES];

  assign cfg_ok       = (bus.thr_heat < bus.thr_target) && (bus.thr_target < bus.thr_cool);
  assign heat_allowed = (bus.mode == 2'b01) || (bus.mode == 2'b11);
  assign cool_allowed = (bus.mode == 2'b10) || (bus.mode == 2'b11);

  for (genvar g = 0; g < N_ZONES; g++) begin : g_temp
    assign zone_temp[g] = bus.temperature[g*TEMP_W +: TEMP_W];
  end

  // Forced-off paths ignore the min-on dwell; normal turn-off waits for the counter.
  always_comb begin
    cfg_err_d = !cfg_ok;
    heating_d = '0;
    cooling_d = '0;
    lockout_d = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = (cnt_q[i] != '0) ? (cnt_q[i] - CNT_W'(1)) : cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (cfg_ok && heat_allowed && (zone_temp[i] <= bus.thr_heat) && (cnt_q[i] == '0)) begin
            state_d[i] = HEAT;
            cnt_d[i]   = ON_LOAD;
          end else if (cfg_ok && cool_allowed && (zone_temp[i] >= bus.thr_cool) && (cnt_q[i] == '0)) begin
            state_d[i] = COOL;
            cnt_d[i]   = ON_LOAD;
          end else begin
            state_d[i] = IDLE;
          end
        end
        HEAT: begin
          if (!cfg_ok || !heat_allowed
              || ((zone_temp[i] >= bus.thr_target) && (cnt_q[i] == '0))) begin
            state_d[i] = IDLE;
            cnt_d[i]   = OFF_LOAD;
          end else begin
            state_d[i] = HEAT;
          end
        end
        COOL: begin
          if (!cfg_ok || !cool_allowed
              || ((zone_temp[i] <= bus.thr_target) && (cnt_q[i] == '0))) begin
            state_d[i] = IDLE;
            cnt_d[i]   = OFF_LOAD;
          end else begin
            state_d[i] = COOL;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      heating_d[i] = (state_d[i] == HEAT);
      cooling_d[i] = (state_d[i] == COOL);
      lockout_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ZONES; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      heating_q <= '0;
      cooling_q <= '0;
      lockout_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_ZONES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      heating_q <= heating_d;
      cooling_q <= cooling_d;
      lockout_q <= lockout_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.heating = heating_q;
  assign bus.cooling = cooling_q;
  assign bus.lockout = lockout_q;
  assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_hvac_zone_controller.sv
// Table-driven scoreboard bench for hvac_zone_controller plus a full-range sweep
// with an asynchronous reset pulse.
module tb_hvac_zone_controller;

  logic clk;
  logic rst;

  hvac_zone_controller_if #(.N_ZONES(4), .TEMP_W(5)) bus ();

  hvac_zone_controller #(
    .N_ZONES(4), .TEMP_W(5), .MIN_ON_CYCLES(4), .MIN_OFF_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mode;
    logic [4:0]  th;
    logic [4:0]  tt;
    logic [4:0]  tc;
    logic [19:0] temp;
    logic [3:0]  eh;
    logic [3:0]  ec;
    logic [3:0]  el;
    logic        ecfg;
  } vec_t;

  typedef struct packed {
    logic [3:0] eh;
    logic [3:0] ec;
    logic [3:0] el;
    logic       ecfg;
  } exp_t;

  vec_t vecs [$];
  exp_t sb   [$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mkv(input logic [1:0] m, input logic [4:0] th, input logic [4:0] tt,
                               input logic [4:0] tc, input logic [4:0] t0, input logic [4:0] t1,
                               input logic [4:0] t2, input logic [4:0] t3, input logic [3:0] eh,
                               input logic [3:0] ec, input logic [3:0] el, input logic ecfg);
    vec_t v;
    v.mode = m; v.th = th; v.tt = tt; v.tc = tc;
    v.temp = {t3, t2, t1, t0};
    v.eh = eh; v.ec = ec; v.el = el; v.ecfg = ecfg;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_all(input logic [1:0] m, input logic [4:0] t);
    bus.mode        = m;
    bus.thr_heat    = 5'd18;
    bus.thr_target  = 5'd20;
    bus.thr_cool    = 5'd22;
    bus.temperature = {t, t, t, t};
  endtask

  initial begin
    exp_t e;
    vec_t v;
    rst = 1'b1;
    set_all(2'b11, 5'd20);

    // {mode, thr_heat, thr_target, thr_cool, t0, t1, t2, t3, heating, cooling, lockout, cfg_err}
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd22, 5'd20, 5'd20, 5'd20, 4'h0, 4'h1, 4'h1, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd20, 4'h0, 4'h1, 4'h1, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd20, 4'h0, 4'h1, 4'h1, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd20, 4'h0, 4'h1, 4'h0, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd20, 4'h0, 4'h0, 4'h1, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd20, 4'h0, 4'h0, 4'h1, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd20, 4'h0, 4'h0, 4'h1, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd20, 4'h0, 4'h0, 4'h0, 1'b0));
    // zone1: heat, leave at full-scale temperature, off-dwell, then cool
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd18, 5'd20, 5'd20, 4'h2, 4'h0, 4'h2, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd31, 5'd20, 5'd20, 4'h2, 4'h0, 4'h2, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd31, 5'd20, 5'd20, 4'h2, 4'h0, 4'h2, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd31, 5'd20, 5'd20, 4'h2, 4'h0, 4'h0, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd31, 5'd20, 5'd20, 4'h0, 4'h0, 4'h2, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd31, 5'd20, 5'd20, 4'h0, 4'h0, 4'h2, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd31, 5'd20, 5'd20, 4'h0, 4'h0, 4'h2, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd31, 5'd20, 5'd20, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd31, 5'd20, 5'd20, 4'h0, 4'h2, 4'h2, 1'b0));
    // zone2 heats, COOL_ONLY forces it off; OFF forces zone1 off too
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd18, 5'd20, 4'h4, 4'h2, 4'h6, 1'b0));
    vecs.push_back(mkv(2'b10, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd18, 5'd20, 4'h0, 4'h2, 4'h6, 1'b0));
    vecs.push_back(mkv(2'b00, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd18, 5'd20, 4'h0, 4'h0, 4'h6, 1'b0));
    vecs.push_back(mkv(2'b00, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd18, 5'd20, 4'h0, 4'h0, 4'h6, 1'b0));
    vecs.push_back(mkv(2'b00, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd18, 5'd20, 4'h0, 4'h0, 4'h2, 1'b0));
    vecs.push_back(mkv(2'b00, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd18, 5'd20, 4'h0, 4'h0, 4'h0, 1'b0));
    // invalid thresholds, restore, force-off by bad config, re-entry after off-dwell
    vecs.push_back(mkv(2'b11, 5'd21, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd0,  4'h0, 4'h0, 4'h0, 1'b1));
    vecs.push_back(mkv(2'b11, 5'd21, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd0,  4'h0, 4'h0, 4'h0, 1'b1));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd0,  4'h8, 4'h0, 4'h8, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd21, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd0,  4'h0, 4'h0, 4'h8, 1'b1));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd0,  4'h0, 4'h0, 4'h8, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd0,  4'h0, 4'h0, 4'h8, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd0,  4'h0, 4'h0, 4'h0, 1'b0));
    vecs.push_back(mkv(2'b11, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd0,  4'h8, 4'h0, 4'h8, 1'b0));
    vecs.push_back(mkv(2'b00, 5'd18, 5'd20, 5'd22, 5'd20, 5'd20, 5'd20, 5'd0,  4'h0, 4'h0, 4'h8, 1'b0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_heating", bus.heating, 4'h0);
    check("reset_cooling", bus.cooling, 4'h0);
    check("reset_lockout", bus.lockout, 4'h0);
    check("reset_cfg_err", {3'b000, bus.cfg_err}, 4'h0);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      bus.mode        = v.mode;
      bus.thr_heat    = v.th;
      bus.thr_target  = v.tt;
      bus.thr_cool    = v.tc;
      bus.temperature = v.temp;
      sb.push_back('{eh: v.eh, ec: v.ec, el: v.el, ecfg: v.ecfg});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d_heating", k), bus.heating, e.eh);
      check($sformatf("v%0d_cooling", k), bus.cooling, e.ec);
      check($sformatf("v%0d_lockout", k), bus.lockout, e.el);
      check($sformatf("v%0d_cfg_err", k), {3'b000, bus.cfg_err}, {3'b000, e.ecfg});
    end

    // full-range sweep up and down with an async reset pulse while all zones cool
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 64; s++) begin
      logic [4:0] t;
      t = (s < 32) ? 5'(s) : 5'(63 - s);
      for (int c = 0; c < 2; c++) begin
        set_all(2'b11, t);
        @(posedge clk);
        #1;
        check("sweep_never_both", bus.heating & bus.cooling, 4'h0);
        if (s == 26 && c == 0) begin
          check("sweep_cooling_before_rst", bus.cooling, 4'hF);
          #2;
          rst = 1'b1;
          #1;
          check("rst_async_heating", bus.heating, 4'h0);
          check("rst_async_cooling", bus.cooling, 4'h0);
          check("rst_async_lockout", bus.lockout, 4'h0);
          @(posedge clk);
          #1;
          rst = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
